// File: rtl/key_event_sequencer.sv
// key_event_sequencer: Avalon-MM master for a key PIO. It programs the PIO irq
// mask, services each interrupt by reading and then clearing edge_capture, and
// queues {timestamp, key_bits} events in a small FIFO for downstream control logic.
module key_event_sequencer #(
  parameter int unsigned KEYS       = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [KEYS-1:0]          cfg_mask,
  input  logic                     cfg_load,
  input  logic                     pio_irq,
  output logic [1:0]               avm_address,
  output logic                     avm_chipselect,
  output logic                     avm_write_n,
  output logic [31:0]              avm_writedata,
  input  logic [31:0]              avm_readdata,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [TS_WIDTH+KEYS-1:0] evt_data,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned EVT_W = TS_WIDTH + KEYS;

  typedef enum logic [2:0] {
    IDLE,
    WMASK,
    RCAP,
    RWAIT,
    WCLR,
    PUSH,
    GUARD
  } state_e;

  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] ts_snap_q, ts_snap_d;
  logic [KEYS-1:0]     mask_q, mask_d;
  logic                cfg_pending_q, cfg_pending_d;
  logic [KEYS-1:0]     cap_q, cap_d;
  logic [1:0]          addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                write_n_q, write_n_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                push;

  logic [EVT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [EVT_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                pop, full, push_ok;

  // Only the low KEYS bits of readdata carry edge_capture content.
  if (KEYS < 32) begin : g_rdata_unused
    logic rdata_unused;
    assign rdata_unused = |avm_readdata[31:KEYS];
  end

  // Sequencer next-state; bus outputs are computed for the state being entered
  // so that they come straight from flops while that state is current.
  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + TS_WIDTH'(1);
    ts_snap_d     = ts_snap_q;
    mask_d        = cfg_load ? cfg_mask : mask_q;
    cfg_pending_d = cfg_pending_q | cfg_load;
    cap_d         = cap_q;
    push          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_pending_q) begin
          state_d = WMASK;
        end else if (pio_irq) begin
          ts_snap_d = ts_q;
          state_d   = RCAP;
        end
      end
      WMASK: begin
        if (!cfg_load) cfg_pending_d = 1'b0;
        state_d = IDLE;
      end
      RCAP:  state_d = RWAIT;
      RWAIT: begin
        cap_d   = avm_readdata[KEYS-1:0] & mask_q;
        state_d = WCLR;
      end
      WCLR:  state_d = PUSH;
      PUSH: begin
        push    = |cap_q;
        state_d = GUARD;
      end
      GUARD: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_d    = addr_q;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    wdata_d   = '0;
    unique case (state_d)
      WMASK: begin
        addr_d    = 2'd2;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = 32'(mask_d);
      end
      RCAP: begin
        addr_d = 2'd3;
        cs_d   = 1'b1;
      end
      RWAIT: addr_d = 2'd3;
      WCLR: begin
        addr_d    = 2'd3;
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        wdata_d   = 32'(cap_d);
      end
      default: ;
    endcase
  end

  // Sequencer, timestamp and bus registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ts_q          <= '0;
      ts_snap_q     <= '0;
      mask_q        <= '0;
      cfg_pending_q <= 1'b1;
      cap_q         <= '0;
      addr_q        <= '0;
      cs_q          <= 1'b0;
      write_n_q     <= 1'b1;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      ts_snap_q     <= ts_snap_d;
      mask_q        <= mask_d;
      cfg_pending_q <= cfg_pending_d;
      cap_q         <= cap_d;
      addr_q        <= addr_d;
      cs_q          <= cs_d;
      write_n_q     <= write_n_d;
      wdata_q       <= wdata_d;
    end
  end

  // Event FIFO next-state: a pop frees room for a push in the same cycle.
  always_comb begin
    pop      = (count_q != '0) && evt_ready;
    full     = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok  = push && (!full || pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {ts_snap_q, cap_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q && !ovf_clr) || (push && full && !pop);
  end

  // Event FIFO storage and overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = wdata_q;
  assign evt_valid      = (count_q != '0);
  assign evt_data       = mem_q[rd_ptr_q];
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Bench for key_event_sequencer: a behavioural key PIO (irq_mask, bit-clearing
// edge_capture, registered readdata) plus an event scoreboard.
module tb_key_event_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  cfg_mask;
  logic        cfg_load;
  logic        pio_irq;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [19:0] evt_data;
  logic        ovf;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  key_event_sequencer #(.KEYS(4), .FIFO_DEPTH(4), .TS_WIDTH(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_mask       (cfg_mask),
    .cfg_load       (cfg_load),
    .pio_irq        (pio_irq),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .ovf            (ovf),
    .ovf_clr        (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PIO model (not reset by the sequencer's reset)
  logic [3:0]  pio_mask  = 4'h0;
  logic [3:0]  pio_edge  = 4'h0;
  logic [3:0]  press     = 4'h0;
  logic [31:0] pio_rdata = 32'h0;

  assign pio_irq      = |(pio_edge & pio_mask);
  assign avm_readdata = pio_rdata;

  always @(posedge clk) begin
    if (avm_chipselect && avm_write_n)
      pio_rdata <= (avm_address == 2'd3) ? {28'h0, pio_edge} :
                   (avm_address == 2'd2) ? {28'h0, pio_mask} : 32'h0;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
      pio_mask <= avm_writedata[3:0];
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
      pio_edge <= (pio_edge & ~avm_writedata[3:0]) | press;
    else
      pio_edge <= pio_edge | press;
  end

  // Bus monitor; cycle k is the k-th clock period after reset release
  int          cyc, bus_cnt, rd_cnt, last_rd_cyc, last_wr2_cyc, last_wr3_cyc;
  logic [31:0] last_wr2_data, last_wr3_data;
  logic [1:0]  first_addr;
  logic        seen;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0; bus_cnt <= 0; rd_cnt <= 0;
      last_rd_cyc <= -1; last_wr2_cyc <= -1; last_wr3_cyc <= -1;
      last_wr2_data <= 32'h0; last_wr3_data <= 32'h0;
      first_addr <= 2'd0; seen <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (avm_chipselect) begin
        bus_cnt <= bus_cnt + 1;
        if (!seen) begin
          seen       <= 1'b1;
          first_addr <= avm_address;
        end
        if (avm_write_n) begin
          rd_cnt      <= rd_cnt + 1;
          last_rd_cyc <= cyc;
        end else if (avm_address == 2'd2) begin
          last_wr2_cyc  <= cyc;
          last_wr2_data <= avm_writedata;
        end else if (avm_address == 2'd3) begin
          last_wr3_cyc  <= cyc;
          last_wr3_data <= avm_writedata;
        end
      end
    end
  end

  // Scoreboard: each accepted FIFO entry must match the oldest expected event
  logic [19:0] sb_q[$];

  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready) begin
      if (sb_q.size() == 0) chk("evt_extra", 64'(evt_data), 64'hFFFFF);
      else                  chk("evt_data", 64'(evt_data), 64'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int k);
    int n = 0;
    while (cyc < k && n < 500) begin
      tick();
      n++;
    end
    chk("wait_cycle", 64'(cyc), 64'(k));
  endtask

  // Press keys during the current cycle p; the sequencer samples irq at t = p+1.
  task automatic service(input logic [3:0] keys, input logic [3:0] cap,
                         input bit expect_push, output int t);
    t     = cyc + 1;
    press = keys;
    if (expect_push) sb_q.push_back({16'(t), cap});
    tick();
    press = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, r;
    logic [3:0] ov_keys [5];
    ov_keys = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
    cfg_mask = 4'hF; cfg_load = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", 64'(avm_address), 64'd0);
    chk("rst_cs", 64'(avm_chipselect), 64'd0);
    chk("rst_wn", 64'(avm_write_n), 64'd1);
    chk("rst_wdata", 64'(avm_writedata), 64'd0);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_data", 64'(evt_data), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // Release with mask load: one write of 0xF to addr 2, then silence
    tick(); reset_n = 1'b1; cfg_load = 1'b1;
    tick(); cfg_load = 1'b0;
    wait_cyc(12); @(negedge clk);
    chk("init_bus_cnt", 64'(bus_cnt), 64'd1);
    chk("init_first_addr", 64'(first_addr), 64'd2);
    chk("init_wr_cyc", 64'(last_wr2_cyc), 64'd1);
    chk("init_wr_data", 64'(last_wr2_data), 64'hF);

    // Key 2 service timing
    tick(); evt_ready = 1'b1;
    service(4'b0100, 4'b0100, 1'b1, t);
    wait_cyc(t + 4); @(negedge clk);
    chk("k2_valid_early", 64'(evt_valid), 64'd0);
    wait_cyc(t + 5); @(negedge clk);
    chk("k2_valid", 64'(evt_valid), 64'd1);
    chk("k2_irq_low", 64'(pio_irq), 64'd0);
    wait_cyc(t + 7); @(negedge clk);
    chk("k2_rd_cyc", 64'(last_rd_cyc), 64'(t + 1));
    chk("k2_clr_cyc", 64'(last_wr3_cyc), 64'(t + 3));
    chk("k2_clr_data", 64'(last_wr3_data), 64'h4);

    // Mask 0011, keys 0 and 3 together
    tick(); c = cyc; cfg_mask = 4'b0011; cfg_load = 1'b1;
    tick(); cfg_load = 1'b0;
    wait_cyc(c + 5); @(negedge clk);
    chk("m3_wr_cyc", 64'(last_wr2_cyc), 64'(c + 2));
    chk("m3_wr_data", 64'(last_wr2_data), 64'h3);
    tick();
    service(4'b1001, 4'b0001, 1'b1, t);
    wait_cyc(t + 7); @(negedge clk);
    chk("m3_clr_data", 64'(last_wr3_data), 64'h1);
    r = rd_cnt;
    tick();
    service(4'b1000, 4'b0000, 1'b0, t);
    wait_cyc(t + 10); @(negedge clk);
    chk("m3_no_irq", 64'(pio_irq), 64'd0);
    chk("m3_no_read", 64'(rd_cnt), 64'(r));

    // Unmasking key 3 lets the stale capture through right after WMASK
    tick(); c = cyc; cfg_mask = 4'hF; cfg_load = 1'b1;
    sb_q.push_back({16'(c + 3), 4'b1000});
    tick(); cfg_load = 1'b0;
    wait_cyc(c + 12); @(negedge clk);
    chk("unmask_rd_cyc", 64'(last_rd_cyc), 64'(c + 4));
    chk("unmask_clr", 64'(last_wr3_data), 64'h8);

    // Overflow: five events into a four-deep FIFO
    tick(); evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      service(ov_keys[i], ov_keys[i], i < 4, t);
      wait_cyc(t + 6);
    end
    @(negedge clk);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("full_valid", 64'(evt_valid), 64'd1);
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 64'(ovf), 64'd0);

    // Push in the same cycle as a pop from a full FIFO
    tick();
    service(4'b0110, 4'b0110, 1'b1, t);
    wait_cyc(t + 4); evt_ready = 1'b1;
    tick(); evt_ready = 1'b0;
    wait_cyc(t + 6); @(negedge clk);
    chk("pushpop_ovf", 64'(ovf), 64'd0);
    tick(); evt_ready = 1'b1;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    @(negedge clk);
    chk("drain_sb", 64'(sb_q.size()), 64'd0);
    chk("drain_valid", 64'(evt_valid), 64'd0);

    // cfg_load during RWAIT: service unaffected, WMASK right after GUARD->IDLE
    tick();
    service(4'b0001, 4'b0001, 1'b1, t);
    wait_cyc(t + 2); cfg_mask = 4'b1110; cfg_load = 1'b1;
    tick(); cfg_load = 1'b0;
    wait_cyc(t + 10); @(negedge clk);
    chk("rw_clr_data", 64'(last_wr3_data), 64'h1);
    chk("rw_clr_cyc", 64'(last_wr3_cyc), 64'(t + 3));
    chk("rw_wm_cyc", 64'(last_wr2_cyc), 64'(t + 7));
    chk("rw_wm_data", 64'(last_wr2_data), 64'hE);
    tick(); cfg_mask = 4'hF; cfg_load = 1'b1;
    tick(); cfg_load = 1'b0;
    wait_cyc(cyc + 5);

    // Reset asserted during WCLR
    service(4'b0100, 4'b0100, 1'b0, t);
    wait_cyc(t + 3); @(negedge clk);
    chk("wclr_wn", 64'(avm_write_n), 64'd0);
    chk("wclr_addr", 64'(avm_address), 64'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_wn", 64'(avm_write_n), 64'd1);
    chk("mid_rst_cs", 64'(avm_chipselect), 64'd0);
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    chk("mid_rst_addr", 64'(avm_address), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; cfg_load = 1'b1;
    sb_q.push_back({16'd2, 4'b0100});
    tick(); cfg_load = 1'b0;
    wait_cyc(10); @(negedge clk);
    chk("rerst_first_addr", 64'(first_addr), 64'd2);
    chk("rerst_wr_cyc", 64'(last_wr2_cyc), 64'd1);
    chk("rerst_rd_cyc", 64'(last_rd_cyc), 64'd3);
    chk("rerst_clr_data", 64'(last_wr3_data), 64'h4);
    chk("rerst_sb", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
